// File: rtl/aes_spi_pkg.sv
// aes_spi_pkg: shared types and sizing helpers for the AES SPI decrypt front-end.
package aes_spi_pkg;
    typedef enum logic [2:0] {IDLE, RX, RX_WAIT, READY, TX} state_t;
    localparam int BLK_W = 128;
    localparam int CNT_W = $clog2(BLK_W + 256 + 1);
    function automatic int key_w(input int nk);
        return 32 * nk;
    endfunction
    function automatic int frame_w(input int nk);
        return BLK_W + key_w(nk);
    endfunction
endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: synchronises the SPI pins into clk and produces sclk/cs_n edge pulses.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sclk,
    input  logic i_cs_n,
    input  logic i_mosi,
    output logic o_sclk_rise,
    output logic o_sclk_fall,
    output logic o_cs_rise,
    output logic o_cs_fall,
    output logic o_mosi
);
    logic [SYNC_STAGES-1:0] r_sclk, r_cs, r_mosi;
    logic r_sclk_d, r_cs_d;
    logic w_sclk, w_cs;
    assign w_sclk = r_sclk[SYNC_STAGES-1];
    assign w_cs   = r_cs[SYNC_STAGES-1];
    assign o_mosi = r_mosi[SYNC_STAGES-1];
    assign o_sclk_rise = w_sclk && !r_sclk_d;
    assign o_sclk_fall = !w_sclk && r_sclk_d;
    assign o_cs_rise = w_cs && !r_cs_d;
    assign o_cs_fall = !w_cs && r_cs_d;
    // cs_n resets low so a frame already in progress cannot produce a fall until cs_n is seen high
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sclk   <= '0;
            r_cs     <= '0;
            r_mosi   <= '0;
            r_sclk_d <= 1'b0;
            r_cs_d   <= 1'b0;
        end else begin
            r_sclk   <= SYNC_STAGES'({r_sclk, i_sclk});
            r_cs     <= SYNC_STAGES'({r_cs, i_cs_n});
            r_mosi   <= SYNC_STAGES'({r_mosi, i_mosi});
            r_sclk_d <= w_sclk;
            r_cs_d   <= w_cs;
        end
    end
endmodule

// File: rtl/aes_spi_dec_frontend.sv
// aes_spi_dec_frontend: SPI mode-0 slave feeding a combinational AES inverse-cipher core.
// AES_SPI_KEY_RETAIN_EN: accept 128-bit ciphertext-only frames that reuse the last key.
module aes_spi_dec_frontend
    import aes_spi_pkg::*;
#(
    parameter int NK          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CORE_LAT    = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_spi_sclk,
    input  logic                   i_spi_cs_n,
    input  logic                   i_spi_mosi,
    output logic                   o_spi_miso,
    output logic [BLK_W-1:0]       o_core_in,
    output logic [key_w(NK)-1:0]   o_core_key,
    input  logic [BLK_W-1:0]       i_core_out,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_frame_err
);
    localparam int KEY_W = key_w(NK);
    localparam int FRM_W = frame_w(NK);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall, w_mosi;
    logic w_full, w_blk_only, w_tx_ok, w_lat_done;
    state_t r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [FRM_W-1:0] r_rx, w_rx_nxt;
    logic [BLK_W-1:0] r_tx, r_pt;
    logic [3:0] r_lat;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_sclk(i_spi_sclk), .i_cs_n(i_spi_cs_n), .i_mosi(i_spi_mosi),
        .o_sclk_rise(w_sclk_rise), .o_sclk_fall(w_sclk_fall),
        .o_cs_rise(w_cs_rise), .o_cs_fall(w_cs_fall), .o_mosi(w_mosi)
    );

    // The bit arriving with a cs_n rise is folded in before the length check
    assign w_cnt_nxt  = (w_sclk_rise && r_cnt != CNT_MAX) ? r_cnt + 1'b1 : r_cnt;
    assign w_rx_nxt   = w_sclk_rise ? {r_rx[FRM_W-2:0], w_mosi} : r_rx;
    assign w_full     = w_cnt_nxt == CNT_W'(FRM_W);
    assign w_tx_ok    = w_cnt_nxt == CNT_W'(BLK_W);
    assign w_lat_done = r_lat == 4'(CORE_LAT - 1);
`ifdef AES_SPI_KEY_RETAIN_EN
    assign w_blk_only = w_cnt_nxt == CNT_W'(BLK_W);
`else
    assign w_blk_only = 1'b0;
`endif
    assign o_busy     = r_state == RX_WAIT || r_state == READY;
    assign o_spi_miso = r_state == TX && r_tx[BLK_W-1];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_cs_fall) w_state_nxt = RX;
            RX:      if (w_cs_rise) w_state_nxt = (w_full || w_blk_only) ? RX_WAIT : IDLE;
            RX_WAIT: if (w_lat_done) w_state_nxt = READY;
            READY:   if (w_cs_fall) w_state_nxt = TX;
            TX:      if (w_cs_rise) w_state_nxt = w_tx_ok ? IDLE : READY;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= IDLE;
        else r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt       <= '0;
            r_rx        <= '0;
            r_tx        <= '0;
            r_pt        <= '0;
            r_lat       <= '0;
            o_core_in   <= '0;
            o_core_key  <= '0;
            o_done      <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_done      <= r_state == RX_WAIT && w_lat_done;
            o_frame_err <= w_cs_rise && ((r_state == RX && !(w_full || w_blk_only)) ||
                                         (r_state == TX && !w_tx_ok));
            r_cnt       <= (r_state == RX || r_state == TX) ? w_cnt_nxt : '0;
            r_lat       <= (r_state == RX_WAIT) ? r_lat + 1'b1 : '0;
            if (r_state == RX)
                r_rx <= w_rx_nxt;
            if (r_state == RX && w_cs_rise && w_full) begin
                o_core_in  <= w_rx_nxt[FRM_W-1 -: BLK_W];
                o_core_key <= w_rx_nxt[KEY_W-1:0];
            end
            if (r_state == RX && w_cs_rise && w_blk_only)
                o_core_in <= w_rx_nxt[BLK_W-1:0];
            if (r_state == RX_WAIT && w_lat_done) begin
                r_pt <= i_core_out;
                r_tx <= i_core_out;
            end else if (r_state == TX && w_cs_rise && !w_tx_ok)
                r_tx <= r_pt;
            else if (r_state == TX && w_sclk_fall)
                r_tx <= r_tx << 1;
        end
    end
endmodule
